// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin packet arbiter driving a 2:1 data mux onto one sink.
// Whole packets are granted. A hold limit preempts a long packet when the other side waits.
module mux2_rr_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              gnt_a,
  output logic              gnt_b
);

  localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;     // 0: A has priority on a tie, 1: B
  logic [CNT_W-1:0] cnt_q, cnt_d;     // beats moved under the current grant
  logic             xfer;
  logic             hold_hit;

  // Combinational pass-through of the granted requester onto the sink port.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state_q)
      GNT_A: begin
        out_valid = a_valid;
        out_data  = a_data;
        out_last  = a_last;
        a_ready   = out_ready;
      end
      GNT_B: begin
        out_valid = b_valid;
        out_data  = b_data;
        out_last  = b_last;
        b_ready   = out_ready;
      end
      default: ;
    endcase
  end

  assign xfer     = out_valid & out_ready;
  // True when the beat in flight is the MAX_HOLD-th (or later, once saturated).
  assign hold_hit = (cnt_q >= HOLD_LAST);

  // Next-state, priority pointer and beat counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || !ptr_q)) begin
          state_d = GNT_A;
        end else if (b_valid) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (xfer) begin
          if (a_last || (hold_hit && b_valid)) begin
            ptr_d   = 1'b1;
            state_d = b_valid ? GNT_B : IDLE;
          end else if (cnt_q != HOLD_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GNT_B: begin
        if (xfer) begin
          if (b_last || (hold_hit && a_valid)) begin
            ptr_d   = 1'b0;
            state_d = a_valid ? GNT_A : IDLE;
          end else if (cnt_q != HOLD_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Any grant change starts the new holder from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State, pointer, counter and the registered grant/select decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      sel     <= 1'b0;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel     <= (state_d == GNT_B);
      gnt_a   <= (state_d == GNT_A);
      gnt_b   <= (state_d == GNT_B);
    end
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream channel between two requesters, A and B, through a 2:1 data mux.
- Owns the mux select. Grants whole packets, delimited by a last flag, with valid/ready handshakes on both sides.
- Enforces a maximum-hold limit so one requester cannot starve the other.
- Sits between two packet sources and a single sink port.

Parameters:
DATA_W, 8, width of data on each requester and on the output
MAX_HOLD, 4, maximum beats transferred per grant while the other requester is waiting (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  requester A has a beat
a_data  input  DATA_W  requester A data
a_last  input  1  requester A beat is last of packet
a_ready  output  1  beat from A accepted this cycle
b_valid  input  1  requester B has a beat
b_data  input  DATA_W  requester B data
b_last  input  1  requester B beat is last of packet
b_ready  output  1  beat from B accepted this cycle
out_valid  output  1  output beat valid
out_data  output  DATA_W  muxed data
out_last  output  1  muxed last flag
out_ready  input  1  sink accepts beat
sel  output  1  registered mux select (0=A, 1=B)
gnt_a  output  1  A currently holds grant
gnt_b  output  1  B currently holds grant

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, sel=0, gnt_a=gnt_b=0, beat count=0, priority pointer=A.
  - Combinational outputs in IDLE: out_valid=0, a_ready=b_ready=0.
  - Reset asserted mid-packet drops the grant immediately. Any beat not handshaken is not transferred.
- States: IDLE, GNT_A, GNT_B. sel, gnt_a and gnt_b are registered from the state (GNT_B -> sel=1).
- IDLE decision:
  - Only a_valid -> GNT_A next cycle.
  - Only b_valid -> GNT_B next cycle.
  - Both -> grant the requester named by the priority pointer.
  - Neither -> stay in IDLE.
  - Grant latency: 1 cycle from valid to grant. No beat transfers in IDLE.
- GNT_X datapath (combinational pass-through):
  - out_valid=x_valid, out_data=x_data, out_last=x_last.
  - x_ready=out_ready. The other requester's ready is 0.
- Handshake:
  - A beat transfers on a cycle with out_valid & out_ready.
  - Requesters must hold data, last and valid stable until ready.
  - The sink may stall indefinitely; the grant is held through stalls.
- Beat counter: increments on each transfer and clears on every grant change.
- Release conditions, evaluated on a transfer cycle:
  - (a) the transferring beat has x_last=1, or
  - (b) count reaches MAX_HOLD and the other requester's valid is 1 (forced preemption mid-packet; the packet resumes on its next grant).
  - Reaching MAX_HOLD with the other requester idle does not release; the count saturates.
- On release:
  - Pointer moves to the other requester.
  - If the other requester's valid=1, go directly to GNT_other (no IDLE bubble).
  - Otherwise go to IDLE.
- If x_valid drops while granted without last, the grant is held. Requesters must not abandon packets.
- Simultaneous release and new request from the same requester: the other requester wins if valid, otherwise the same requester is re-granted via IDLE (one bubble cycle).
- Fairness: with both requesters continuously valid, grants alternate strictly A, B, A, B…

Test Plan:
- Reset: rst_n low asynchronously mid-cycle -> sel=0, gnt_a=gnt_b=0, out_valid=0, a_ready=b_ready=0 without waiting for a clock edge.
- Single requester: A sends a 3-beat packet (0x11, 0x22, 0x33 with last on the third), out_ready=1.
  - gnt_a rises 1 cycle after a_valid.
  - out_data sequence is 0x11, 0x22, 0x33.
  - State returns to IDLE, pointer=B.
- Contention from reset: a_valid and b_valid asserted together, each with 2-beat packets.
  - A is granted first, then B immediately after A's last beat, with no IDLE cycle.
  - Output order: A0, A1, B0, B1.
- Preemption: A sends a 6-beat packet, B becomes valid at A's beat 2, MAX_HOLD=4.
  - A is released after beat 4. B's packet transfers.
  - A is re-granted and sends beats 5 and 6.
- Backpressure: out_ready toggles 1, 0, 0, 1 during a B packet.
  - b_ready mirrors out_ready.
  - out_data holds stable while stalled.
  - No beat is duplicated or lost.
  - Grant is held across the stalls.
- Hold saturation: A sends an 8-beat packet with B idle, MAX_HOLD=4 -> A keeps the grant for all 8 beats.
